prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//  Byte-stream program loader: the write side of the 32-entry control-word program store that the PC indexes.
//  Accepts a framed byte stream: length, 2 bytes per control word, optional checksum.
//  Writes each assembled 10-bit word into program memory at ascending addresses.
//  Holds the PC (core_hold) while loading.
// PARAMETERS
//  PROG_DEPTH  32  program store entries; address width = $clog2(PROG_DEPTH) = 5
//  CW_W        10  control word width {RegAddr[3:0],ALUCode[2:0],Reg_CE,CY_CE,A_CE} = [9:6],[5:3],[2],[1],[0]
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  start      in   1   1-cycle pulse: begin a load; honoured only in IDLE, DONE, ERR
//  in_data    in   8   stream byte
//  in_valid   in   1   in_data valid
//  in_ready   out  1   loader accepts byte; a byte transfers when in_valid & in_ready
//  wr_en      out  1   program-store write strobe, one cycle per word
//  wr_addr    out  5   write address
//  wr_data    out  10  control word
//  core_hold  out  1   freeze PC / core
//  load_done  out  1   level: last load completed OK
//  load_err   out  1   level: last load failed
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, wr_en, core_hold, load_done, load_err = 0; wr_addr=0; wr_data=0; count, checksum cleared.
//  A reset mid-load aborts the load. Words already written stay in the store.
//  States: IDLE -> LEN -> LO -> HI -> (CHK) -> DONE | ERR.
//  in_ready=1 exactly in LEN, LO, HI, CHK. core_hold=1 in LEN, LO, HI, CHK, ERR.
//  Each handshake advances exactly one state. Without in_valid the state holds indefinitely.
//  start (IDLE/DONE/ERR): go to LEN; clear load_done, load_err, addr, checksum. start in other states is ignored.
//  LEN: N = in_data.
//   - N in 1..32: latch remaining=N, go to LO.
//   - N = 0 or N > 32: go to ERR.
//  LO: latch byte as word[7:0]; go to HI.
//  HI: byte[7:2] must be 0, otherwise go to ERR with no write. Byte[1:0] = word[9:8].
//   - Next cycle: wr_en=1, wr_addr=addr, wr_data=word (write latency = 1 cycle after the HI handshake).
//   - Then addr++ and remaining--.
//   - remaining was 1 -> go to CHK (or DONE, see CONFIGURATION); otherwise go back to LO.
//  wr_en is registered and never high for 2 consecutive cycles (the next LO handshake needs >=1 cycle).
//  Address never wraps: at most 32 writes, addresses 0..N-1.
//  DONE: load_done=1, core_hold=0. ERR: load_err=1, core_hold stays 1.
//  Both DONE and ERR hold until start or rst.
//  start and in_valid in the same cycle in DONE: start wins; the byte is not consumed (in_ready=0).
// CONFIGURATION
//  PROG_LOADER_CHECKSUM_EN defined:
//   - running XOR of every LO and HI byte.
//   - CHK consumes 1 byte: equal to XOR -> DONE; else ERR. Words already written remain written.
//  Not defined: no CHK state, no XOR register; after the final write go directly to DONE.
// STRUCTURE
//  Package uproc_pkg: PROG_DEPTH, CW_W, field offsets/widths of the control word,
//  ALU opcode constants (ADD, SUB, ...), typedef enum loader_state_t.
//  Sub-module prog_cksum (clear, en, byte in, 8-bit XOR out), instantiated only under PROG_LOADER_CHECKSUM_EN.
//  FSM, counters and write port live in prog_loader.
// TESTING
//  1) start; stream 02,41,00,82,01,(cksum C2) -> wr (0,0x041), (1,0x182); load_done=1; core_hold falls in DONE.
//  2) LEN=00 or LEN=21 -> ERR, no wr_en, load_err=1, core_hold=1, in_ready=0.
//  3) HI byte 0x04 on word 0 -> ERR, zero writes; start then clears load_err.
//  4) LEN=32, 64 payload bytes with random in_valid gaps -> exactly 32 writes, addr 0..31 in order, no wrap.
//  5) CHECKSUM_EN: bad checksum -> all N words written, then load_err=1. Macro off: same stream minus cksum -> DONE.
//  6) rst asserted mid-HI -> next cycle all outputs 0, state IDLE; start mid-load ignored.

Source files
------------

// File: rtl/uproc_pkg.sv
// Shared constants and types for the micro-processor program path.
// Covers the control-word layout, the ALU opcodes and the program loader FSM states.
package uproc_pkg;

    localparam int PROG_DEPTH = 32;
    localparam int ADDR_W     = $clog2(PROG_DEPTH);
    localparam int CW_W       = 10;

    // Control word: {RegAddr[3:0], ALUCode[2:0], Reg_CE, CY_CE, A_CE}
    localparam int CW_REGADDR_LSB = 6;
    localparam int CW_REGADDR_W   = 4;
    localparam int CW_ALU_LSB     = 3;
    localparam int CW_ALU_W       = 3;
    localparam int CW_REG_CE_BIT  = 2;
    localparam int CW_CY_CE_BIT   = 1;
    localparam int CW_A_CE_BIT    = 0;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_PASS = 3'd5;
    localparam logic [2:0] ALU_SHL  = 3'd6;
    localparam logic [2:0] ALU_SHR  = 3'd7;

    typedef enum logic [2:0] {
        LS_IDLE = 3'd0,
        LS_LEN  = 3'd1,
        LS_LO   = 3'd2,
        LS_HI   = 3'd3,
        LS_CHK  = 3'd4,
        LS_DONE = 3'd5,
        LS_ERR  = 3'd6
    } loader_state_t;

endpackage

// File: rtl/prog_cksum.sv
// Running XOR over the payload bytes of a program load.
// Only instantiated when PROG_LOADER_CHECKSUM_EN is defined.
module prog_cksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] xor_out
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            xor_out <= 8'd0;
        end else if (en) begin
            xor_out <= xor_out ^ din;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: frames length, two bytes per control word and an optional
// checksum (PROG_LOADER_CHECKSUM_EN), writing words to the program store while holding the core.
import uproc_pkg::*;

module prog_loader (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CW_W-1:0] wr_data,
    output logic            core_hold,
    output logic            load_done,
    output logic            load_err,
    output logic [2:0]      dbg_state
);

    localparam logic [2:0] S_IDLE = LS_IDLE;
    localparam logic [2:0] S_LEN  = LS_LEN;
    localparam logic [2:0] S_LO   = LS_LO;
    localparam logic [2:0] S_HI   = LS_HI;
    localparam logic [2:0] S_CHK  = LS_CHK;
    localparam logic [2:0] S_DONE = LS_DONE;
    localparam logic [2:0] S_ERR  = LS_ERR;

    // Stream handshake: a byte transfers on a rising edge where in_valid & in_ready;
    // in_ready depends only on state, never on in_valid.
    logic [2:0]      state;
    logic [ADDR_W:0] addr;       // one bit wider so a full load never wraps back to 0
    logic [ADDR_W:0] remaining;
    logic [7:0]      word_lo;
    logic            restart;
    logic            len_ok;
    logic            hi_ok;
    logic [2:0]      last_word_next;

    assign restart = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign len_ok  = (in_data != 8'd0) && (in_data <= 8'(PROG_DEPTH));
    assign hi_ok   = (in_data[7:2] == 6'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] cksum;
    logic       cksum_en;

    assign cksum_en       = in_valid && (state == S_LO || state == S_HI);
    assign last_word_next = S_CHK;

    prog_cksum u_cksum (
        .clk     (clk),
        .rst     (rst),
        .clear   (restart),
        .en      (cksum_en),
        .din     (in_data),
        .xor_out (cksum)
    );
`else
    assign last_word_next = S_DONE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            word_lo   <= 8'd0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (restart) begin
                        state <= S_LEN;
                        addr  <= '0;
                    end
                end
                S_LEN: begin
                    if (in_valid) begin
                        if (len_ok) begin
                            remaining <= in_data[ADDR_W:0];
                            state     <= S_LO;
                        end else begin
                            state <= S_ERR;
                        end
                    end
                end
                S_LO: begin
                    if (in_valid) begin
                        word_lo <= in_data;
                        state   <= S_HI;
                    end
                end
                S_HI: begin
                    if (in_valid) begin
                        if (!hi_ok) begin
                            state <= S_ERR;
                        end else begin
                            wr_en     <= 1'b1;
                            wr_addr   <= addr[ADDR_W-1:0];
                            wr_data   <= {in_data[1:0], word_lo};
                            addr      <= addr + 1'b1;
                            remaining <= remaining - 1'b1;
                            state     <= (remaining == 1) ? last_word_next : S_LO;
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (in_valid) begin
                        state <= (in_data == cksum) ? S_DONE : S_ERR;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == S_LEN) || (state == S_LO) || (state == S_HI) || (state == S_CHK);
        core_hold = in_ready || (state == S_ERR);
        load_done = (state == S_DONE);
        load_err  = (state == S_ERR);
        dbg_state = state;
    end

endmodule
